// File: rtl/wm_pingpong_buf.sv
`default_nettype none
// ============================================================================
// wm_pingpong_buf : double-buffered weight memory with FIFO bank order and
//                   optional replay of the oldest full bank on read
// Revision: 1.0
// ============================================================================
module wm_pingpong_buf #(
  parameter int    DATA_WIDTH    = 512,
  parameter int    ADDR_WIDTH    = 8,
  parameter int    READ_LATENCY  = 2,
  parameter string MEM_PRIMITIVE = "ultra"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  input  logic                  rd_start,
  input  logic                  rd_keep,
  output logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic [1:0]            bank_full,
  output logic                  ovf_err
);

  localparam int                c_depth    = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] c_addr_one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   c_len_one  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_FULL    = 2'd2,
    ST_READING = 2'd3
  } bank_state_t;

  bank_state_t             r_state     [2];
  bank_state_t             w_state_nxt [2];
  logic [ADDR_WIDTH:0]     r_len       [2];
  logic                    r_wp, r_rp;
  logic [ADDR_WIDTH-1:0]   r_wa, r_ra;
  logic                    r_busy, r_issue, r_keep, r_ovf;
  logic [READ_LATENCY-1:0] r_pv, r_pl;
  logic [DATA_WIDTH-1:0]   r_pd        [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   w_ram_q;
  logic [ADDR_WIDTH:0]     w_waddr, w_raddr;
  logic                    w_wr_acc, w_wr_close, w_rd_acc, w_rd_done, w_addr_last;

  assign wr_ready    = (r_state[r_wp] == ST_EMPTY) || (r_state[r_wp] == ST_FILLING);
  assign rd_ready    = (r_state[r_rp] == ST_FULL) && !r_busy;
  assign w_wr_acc    = wr_valid & wr_ready;
  // The last address of a bank closes the set even without wr_last.
  assign w_wr_close  = w_wr_acc & (wr_last | (&r_wa));
  assign w_rd_acc    = rd_start & rd_ready;
  assign w_addr_last = ({1'b0, r_ra} == (r_len[r_rp] - c_len_one));
  assign w_rd_done   = rd_last;
  assign w_waddr     = {r_wp, r_wa};
  assign w_raddr     = {r_rp, r_ra};

  assign rd_valid = r_pv[READ_LATENCY-1];
  assign rd_last  = r_pv[READ_LATENCY-1] & r_pl[READ_LATENCY-1];
  assign rd_data  = r_pd[READ_LATENCY-1];
  assign ovf_err  = r_ovf;

  for (genvar g = 0; g < 2; g++) begin : g_status
    assign bank_full[g] = (r_state[g] == ST_FULL) || (r_state[g] == ST_READING);
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_wr_acc)
      w_state_nxt[r_wp] = w_wr_close ? ST_FULL : ST_FILLING;
    if (w_rd_acc)
      w_state_nxt[r_rp] = ST_READING;
    if (w_rd_done)
      w_state_nxt[r_rp] = r_keep ? ST_FULL : ST_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) r_state[i] <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= 1'b0;
      r_wa  <= '0;
      r_ovf <= 1'b0;
      for (int i = 0; i < 2; i++) r_len[i] <= '0;
    end else if (w_wr_acc) begin
      if (w_wr_close) begin
        r_len[r_wp] <= {1'b0, r_wa} + c_len_one;
        r_wa        <= '0;
        r_wp        <= ~r_wp;
      end else begin
        r_wa <= r_wa + c_addr_one;
      end
      if (!wr_last && (&r_wa))
        r_ovf <= 1'b1;
    end
  end

  // Sequencer stays busy until rd_last so the next pass starts after the drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_issue <= 1'b0;
      r_keep  <= 1'b0;
      r_ra    <= '0;
      r_rp    <= 1'b0;
    end else begin
      if (w_rd_acc) begin
        r_busy  <= 1'b1;
        r_issue <= 1'b1;
        r_keep  <= rd_keep;
        r_ra    <= '0;
      end else if (r_issue) begin
        if (w_addr_last) r_issue <= 1'b0;
        else             r_ra    <= r_ra + c_addr_one;
      end
      if (w_rd_done) begin
        r_busy <= 1'b0;
        if (!r_keep) r_rp <= ~r_rp;
      end
    end
  end

  if (MEM_PRIMITIVE == "block") begin : g_ram_block
    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] r_mem [2*c_depth];
    always_ff @(posedge clk) if (w_wr_acc) r_mem[w_waddr] <= wr_data;
    assign w_ram_q = r_mem[w_raddr];
  end else if (MEM_PRIMITIVE == "distributed") begin : g_ram_dist
    (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] r_mem [2*c_depth];
    always_ff @(posedge clk) if (w_wr_acc) r_mem[w_waddr] <= wr_data;
    assign w_ram_q = r_mem[w_raddr];
  end else begin : g_ram_ultra
    (* ram_style = "ultra" *) logic [DATA_WIDTH-1:0] r_mem [2*c_depth];
    always_ff @(posedge clk) if (w_wr_acc) r_mem[w_waddr] <= wr_data;
    assign w_ram_q = r_mem[w_raddr];
  end

  // Data stages load only behind a valid word, so rd_data holds between passes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pv <= '0;
      r_pl <= '0;
      for (int i = 0; i < READ_LATENCY; i++) r_pd[i] <= '0;
    end else begin
      r_pv[0] <= r_issue;
      r_pl[0] <= r_issue & w_addr_last;
      if (r_issue) r_pd[0] <= w_ram_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_pv[i] <= r_pv[i-1];
        r_pl[i] <= r_pl[i-1];
        if (r_pv[i-1]) r_pd[i] <= r_pd[i-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wm_pingpong_buf.sv
`default_nettype none
// ============================================================================
// tb_wm_pingpong_buf : self-checking bench against a set-level queue model
// Revision: 1.0
// ============================================================================
module tb_wm_pingpong_buf;

  localparam int DW    = 64;
  localparam int AW    = 8;
  localparam int RL    = 2;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0, wr_last = 1'b0, rd_start = 1'b0, rd_keep = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready, rd_ready, rd_valid, rd_last, ovf_err;
  logic [DW-1:0] rd_data;
  logic [1:0]    bank_full;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: words of all complete/incomplete sets in arrival order, plus set lengths.
  logic [DW-1:0] exp_words [$];
  int            exp_lens  [$];
  int            m_wsets = 0;
  int            m_rsets = 0;
  event          ev_rd_go;

  always #5 clk = ~clk;

  wm_pingpong_buf #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .MEM_PRIMITIVE("ultra")
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_last(wr_last),
    .rd_start(rd_start), .rd_keep(rd_keep), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .bank_full(bank_full), .ovf_err(ovf_err)
  );

  function automatic logic [1:0] front_bank();
    return 2'(1 << (m_rsets % 2));
  endfunction

  task automatic write_set(input int n, input bit last_flag, input bit bubbles, input bit seq);
    int i;
    int guard;
    i = 0;
    guard = 0;
    while (i < n && guard < 5000) begin
      @(negedge clk);
      guard++;
      if (bubbles && ($urandom_range(0, 3) == 0)) begin
        wr_valid = 1'b0;
        wr_last  = 1'b0;
      end else begin
        wr_valid = 1'b1;
        wr_data  = seq ? 64'(i + 1) : {$urandom, $urandom};
        wr_last  = last_flag && (i == n - 1);
        if (wr_ready) begin
          exp_words.push_back(wr_data);
          i++;
          if (wr_last || i == DEPTH) begin
            exp_lens.push_back(i);
            m_wsets++;
          end
        end
      end
    end
    n_checks++; if (i != n) begin n_fail++; $display("FAIL write_accept: accepted %0d words, required %0d", i, n); end
    @(negedge clk);
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic do_read(input bit keep);
    int  len;
    bit  got;
    bit  ev, el;
    got = 1'b0;
    for (int w = 0; w < 1000 && !got; w++) begin
      @(negedge clk);
      got = rd_ready;
    end
    n_checks++;
    if (!got || exp_lens.size() == 0) begin
      n_fail++;
      $display("FAIL read_start: rd_ready=%b model_sets=%0d, required rd_ready=1 with a set", rd_ready, exp_lens.size());
      -> ev_rd_go;
      return;
    end
    len = exp_lens[0];
    rd_start = 1'b1;
    rd_keep  = keep;
    -> ev_rd_go;
    for (int c = 1; c <= len + RL + 1; c++) begin
      @(negedge clk);
      if (c == 1) begin
        rd_start = 1'b0;
        rd_keep  = 1'($urandom_range(0, 1));
      end
      ev = (c >= 1 + RL) && (c <= len + RL);
      el = (c == len + RL);
      n_checks++; if (rd_valid !== ev) begin n_fail++; $display("FAIL read_valid c%0d: got %b required %b", c, rd_valid, ev); end
      n_checks++; if (rd_last !== el) begin n_fail++; $display("FAIL read_last c%0d: got %b required %b", c, rd_last, el); end
      if (ev) begin
        n_checks++; if (rd_data !== exp_words[c-1-RL]) begin n_fail++; $display("FAIL read_data c%0d: got %h required %h", c, rd_data, exp_words[c-1-RL]); end
      end
      if (c <= len + RL) begin
        n_checks++; if (rd_ready !== 1'b0) begin n_fail++; $display("FAIL read_busy c%0d: rd_ready got %b required 0", c, rd_ready); end
      end
    end
    n_checks++; if (rd_data !== exp_words[len-1]) begin n_fail++; $display("FAIL read_hold: got %h required %h", rd_data, exp_words[len-1]); end
    if (!keep) begin
      repeat (len) void'(exp_words.pop_front());
      void'(exp_lens.pop_front());
      m_rsets++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b required 1", wr_ready); end
    n_checks++; if (rd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rd_ready: got %b required 0", rd_ready); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b required 0", rd_valid); end
    n_checks++; if (rd_last !== 1'b0) begin n_fail++; $display("FAIL reset_rd_last: got %b required 0", rd_last); end
    n_checks++; if (rd_data !== '0) begin n_fail++; $display("FAIL reset_rd_data: got %h required 0", rd_data); end
    n_checks++; if (bank_full !== 2'b00) begin n_fail++; $display("FAIL reset_bank_full: got %b required 00", bank_full); end
    n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL reset_ovf_err: got %b required 0", ovf_err); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_wr_ready: got %b required 1", wr_ready); end
  endtask

  task automatic test_basic();
    write_set(4, 1'b1, 1'b0, 1'b1);
    n_checks++; if (bank_full !== 2'b01) begin n_fail++; $display("FAIL basic_full: got %b required 01", bank_full); end
    n_checks++; if (rd_ready !== 1'b1) begin n_fail++; $display("FAIL basic_rd_ready: got %b required 1", rd_ready); end
    do_read(1'b0);
    n_checks++; if (bank_full !== 2'b00) begin n_fail++; $display("FAIL basic_release: got %b required 00", bank_full); end
    n_checks++; if (rd_ready !== 1'b0) begin n_fail++; $display("FAIL basic_rd_ready_after: got %b required 0", rd_ready); end
  endtask

  task automatic test_pingpong();
    write_set(8, 1'b1, 1'b0, 1'b0);
    write_set(8, 1'b1, 1'b0, 1'b0);
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL pp_wr_ready_full: got %b required 0", wr_ready); end
    n_checks++; if (bank_full !== 2'b11) begin n_fail++; $display("FAIL pp_both_full: got %b required 11", bank_full); end
    do_read(1'b0);
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL pp_wr_ready_back: got %b required 1", wr_ready); end
    n_checks++; if (rd_ready !== 1'b1) begin n_fail++; $display("FAIL pp_next_ready: got %b required 1", rd_ready); end
    n_checks++; if (bank_full !== front_bank()) begin n_fail++; $display("FAIL pp_one_left: got %b required %b", bank_full, front_bank()); end
    do_read(1'b0);
    n_checks++; if (bank_full !== 2'b00) begin n_fail++; $display("FAIL pp_drained: got %b required 00", bank_full); end
  endtask

  task automatic test_replay();
    write_set(3, 1'b1, 1'b1, 1'b0);
    for (int p = 0; p < 2; p++) begin
      do_read(1'b1);
      n_checks++; if (bank_full !== front_bank()) begin n_fail++; $display("FAIL replay_kept p%0d: got %b required %b", p, bank_full, front_bank()); end
      n_checks++; if (rd_ready !== 1'b1) begin n_fail++; $display("FAIL replay_ready p%0d: got %b required 1", p, rd_ready); end
    end
    do_read(1'b0);
    n_checks++; if (bank_full !== 2'b00) begin n_fail++; $display("FAIL replay_release: got %b required 00", bank_full); end
  endtask

  task automatic test_overflow();
    n_checks++; if (ovf_err !== 1'b0) begin n_fail++; $display("FAIL ovf_pre: got %b required 0", ovf_err); end
    write_set(DEPTH, 1'b0, 1'b1, 1'b0);
    n_checks++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b required 1", ovf_err); end
    n_checks++; if (bank_full !== front_bank()) begin n_fail++; $display("FAIL ovf_closed: got %b required %b", bank_full, front_bank()); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_wr_ready: got %b required 1", wr_ready); end
    do_read(1'b0);
    n_checks++; if (ovf_err !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b required 1", ovf_err); end
  endtask

  task automatic test_concurrent();
    logic [1:0] ybank;
    bit         coincide;
    write_set(6, 1'b1, 1'b0, 1'b0);
    ybank    = 2'(1 << (m_wsets % 2));
    coincide = 1'b0;
    fork
      do_read(1'b0);
      begin
        @(ev_rd_go);
        write_set(6 + RL, 1'b1, 1'b0, 1'b0);
      end
      begin
        for (int c = 0; c < 6 + RL + 2; c++) begin
          @(negedge clk);
          #1;
          if (wr_valid && wr_ready && wr_last && rd_last) coincide = 1'b1;
        end
      end
    join
    n_checks++; if (coincide !== 1'b1) begin n_fail++; $display("FAIL conc_same_cycle: got %b required 1", coincide); end
    n_checks++; if (bank_full !== ybank) begin n_fail++; $display("FAIL conc_bank_full: got %b required %b", bank_full, ybank); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL conc_wr_ready: got %b required 1", wr_ready); end
    do_read(1'b0);
    n_checks++; if (bank_full !== 2'b00) begin n_fail++; $display("FAIL conc_drained: got %b required 00", bank_full); end
  endtask

  task automatic test_reset_midread();
    bit got;
    write_set(10, 1'b1, 1'b0, 1'b0);
    got = 1'b0;
    for (int w = 0; w < 1000 && !got; w++) begin
      @(negedge clk);
      got = rd_ready;
    end
    rd_start = 1'b1;
    rd_keep  = 1'b0;
    @(negedge clk);
    rd_start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL midrd_valid_before: got %b required 1", rd_valid); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL midrd_valid: got %b required 0", rd_valid); end
    n_checks++; if (bank_full !== 2'b00) begin n_fail++; $display("FAIL midrd_bank_full: got %b required 00", bank_full); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL midrd_wr_ready: got %b required 1", wr_ready); end
    n_checks++; if (rd_ready !== 1'b0) begin n_fail++; $display("FAIL midrd_rd_ready: got %b required 0", rd_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_words.delete();
    exp_lens.delete();
    m_wsets = 0;
    m_rsets = 0;
    write_set(5, 1'b1, 1'b1, 1'b0);
    n_checks++; if (bank_full !== 2'b01) begin n_fail++; $display("FAIL midrd_refill: got %b required 01", bank_full); end
    do_read(1'b0);
    n_checks++; if (bank_full !== 2'b00) begin n_fail++; $display("FAIL midrd_drained: got %b required 00", bank_full); end
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 6; it++) begin
      write_set($urandom_range(1, 20), 1'b1, 1'b1, 1'b0);
      if ($urandom_range(0, 1) == 1) do_read(1'b1);
      do_read(1'b0);
      n_checks++; if (bank_full !== 2'b00) begin n_fail++; $display("FAIL b2b_drained it%0d: got %b required 00", it, bank_full); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pingpong();
    test_replay();
    test_overflow();
    test_concurrent();
    test_reset_midread();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
